// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
//
// Control sequencer for a 4-bit universal binary counter clocked from the
// system clock. It turns single-cycle button requests plus an internal
// prescaled run tick into mutually exclusive one-cycle en / syn_clr / load
// strobes and a registered up level. It supports run/stop, single step,
// direction toggle, halt at the count limits and optional ping-pong reversal.
//
// Parameters
//   DIV    run-mode tick period in clk cycles (>= 4)
//   DIV_W  prescaler width, 2**DIV_W > DIV
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   req_clr   in   pulse: synchronous clear request
//   req_load  in   pulse: load request
//   req_dir   in   pulse: toggle count direction
//   req_run   in   pulse: toggle run/stop
//   req_step  in   pulse: single count (only honoured in STOP)
//   pingpong  in   level: 1 reverses at a limit, 0 halts at a limit
//   max_tick  in   counter is at 15
//   min_tick  in   counter is at 0
//   en        out  one-cycle count strobe
//   up        out  direction level, 1 = up
//   syn_clr   out  one-cycle clear strobe
//   load      out  one-cycle load strobe
//   state     out  00 = STOP, 01 = RUN, 10 = HALT
// -----------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int DIV   = 50_000_000,
    parameter int DIV_W = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_clr,
    input  logic       req_load,
    input  logic       req_dir,
    input  logic       req_run,
    input  logic       req_step,
    input  logic       pingpong,
    input  logic       max_tick,
    input  logic       min_tick,
    output logic       en,
    output logic       up,
    output logic       syn_clr,
    output logic       load,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    // Request slots; lower index means higher service priority.
    localparam int NREQ   = 6;
    localparam int R_CLR  = 0;
    localparam int R_LOAD = 1;
    localparam int R_DIR  = 2;
    localparam int R_RUN  = 3;
    localparam int R_STEP = 4;
    localparam int R_TICK = 5;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_t             state_q, state_d;
    logic               up_q, up_d;
    logic               en_q, en_d;
    logic               clr_q, clr_d;
    logic               load_q, load_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [NREQ-1:0]    pend_q, pend_d;

    logic [NREQ-1:0]    req_vec;
    logic [NREQ-1:0]    live;
    logic [NREQ-1:0]    allowed;
    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    drop;
    logic               tick_raw;
    logic               guard;
    logic               at_limit;

    // The terminal prescaler count is itself a live tick request in that cycle,
    // so an uncontended tick produces en in the following cycle.
    assign tick_raw = (state_q == ST_RUN) && (presc_q == DIV_LAST);
    assign req_vec  = {tick_raw, req_step, req_run, req_dir, req_load, req_clr};
    assign live     = req_vec | pend_q;

    // A strobe high this cycle blocks service, which keeps strobes apart and
    // lets max_tick/min_tick settle after the last strobe.
    assign guard = en_q | clr_q | load_q;

    // Step is only serviceable in STOP and the tick only in RUN; otherwise they
    // are dropped rather than left to block lower-priority slots.
    assign allowed = {state_q == ST_RUN, state_q == ST_STOP, 4'b1111};

    // Isolate the lowest set bit: the highest-priority eligible request.
    assign grant = guard ? '0 : (elig & (~elig + NREQ'(1)));

    always_comb begin
        drop         = '0;
        drop[R_STEP] = (state_q != ST_STOP);
        // Leaving RUN, or restarting the prescaler, discards any queued tick.
        drop[R_TICK] = (state_q != ST_RUN) | grant[R_CLR] | grant[R_LOAD] | grant[R_RUN];
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign elig[gi]   = live[gi] & allowed[gi];
            assign pend_d[gi] = live[gi] & ~grant[gi] & ~drop[gi];
        end
    endgenerate

    assign at_limit = up_q ? max_tick : min_tick;

    always_comb begin
        state_d = state_q;
        up_d    = up_q;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        load_d  = 1'b0;
        presc_d = presc_q;
        if (state_q == ST_RUN) begin
            presc_d = (presc_q == DIV_LAST) ? '0 : presc_q + DIV_W'(1);
        end

        if (grant[R_CLR]) begin
            clr_d   = 1'b1;
            presc_d = '0;
            if (state_q == ST_HALT) state_d = ST_STOP;
        end else if (grant[R_LOAD]) begin
            load_d  = 1'b1;
            presc_d = '0;
            if (state_q == ST_HALT) state_d = ST_STOP;
        end else if (grant[R_DIR]) begin
            up_d = ~up_q;
            if (state_q == ST_HALT) state_d = ST_STOP;
        end else if (grant[R_RUN]) begin
            case (state_q)
                ST_STOP: begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
                default: state_d = ST_STOP;
            endcase
        end else if (grant[R_STEP] | grant[R_TICK]) begin
            if (!at_limit) begin
                en_d = 1'b1;
            end else if (pingpong) begin
                // Reverse and count in the same cycle using the new direction.
                up_d = ~up_q;
                en_d = 1'b1;
            end else if (grant[R_TICK]) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_STOP;
            up_q    <= 1'b1;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            load_q  <= 1'b0;
            presc_q <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            load_q  <= load_d;
            presc_q <= presc_d;
            pend_q  <= pend_d;
        end
    end

    assign en      = en_q;
    assign up      = up_q;
    assign syn_clr = clr_q;
    assign load    = load_q;
    assign state   = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_seq_ctrl
//
// Directed bench for counter_seq_ctrl with DIV = 4. A small behavioural model
// of the 4-bit universal counter closes the loop so max_tick/min_tick follow
// the strobes. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_counter_seq_ctrl;

    localparam int DIV   = 4;
    localparam int DIV_W = 3;

    localparam logic [4:0] M_CLR  = 5'b00001;
    localparam logic [4:0] M_LOAD = 5'b00010;
    localparam logic [4:0] M_DIR  = 5'b00100;
    localparam logic [4:0] M_RUN  = 5'b01000;
    localparam logic [4:0] M_STEP = 5'b10000;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_clr, req_load, req_dir, req_run, req_step;
    logic       pingpong;
    logic       max_tick, min_tick;
    logic       en, up, syn_clr, load;
    logic [1:0] state;
    logic [3:0] q;
    logic [3:0] d_val;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_clr  (req_clr),
        .req_load (req_load),
        .req_dir  (req_dir),
        .req_run  (req_run),
        .req_step (req_step),
        .pingpong (pingpong),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .en       (en),
        .up       (up),
        .syn_clr  (syn_clr),
        .load     (load),
        .state    (state)
    );

    // Model of the downstream counter.
    assign max_tick = (q == 4'd15);
    assign min_tick = (q == 4'd0);

    always @(posedge clk) begin
        if (reset)        q <= 4'd0;
        else if (syn_clr) q <= 4'd0;
        else if (load)    q <= d_val;
        else if (en)      q <= up ? q + 4'd1 : q - 4'd1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Requests are high for exactly one sampling edge; returns at the falling
    // edge of the following cycle, where an uncontended strobe is visible.
    task automatic pulse(input logic [4:0] m);
        @(negedge clk);
        {req_step, req_run, req_dir, req_load, req_clr} = m;
        @(negedge clk);
        {req_step, req_run, req_dir, req_load, req_clr} = 5'b0;
    endtask

    // Number of cycles until en is seen, capped so a stuck DUT cannot hang.
    task automatic wait_en(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!en && cnt < 12);
    endtask

    initial begin
        int cnt;
        int ens;
        int strobes;

        reset    = 1'b1;
        req_clr  = 1'b0;
        req_load = 1'b0;
        req_dir  = 1'b0;
        req_run  = 1'b0;
        req_step = 1'b0;
        pingpong = 1'b0;
        d_val    = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_state", state, 0);
        check("rst_up", up, 1);
        check("rst_strobes", {en, syn_clr, load}, 0);
        check("rst_q", q, 0);

        // Three single steps
        for (int i = 0; i < 3; i++) begin
            pulse(M_STEP);
            check("step_en", en, 1);
            check("step_up", up, 1);
            check("step_qpre", q, i);
            @(negedge clk);
            check("step_en_low", en, 0);
            repeat (3) @(negedge clk);
        end
        check("step_q3", q, 3);

        // Run to the upper limit and halt
        d_val = 4'd13;
        pulse(M_LOAD);
        check("ld13_load", load, 1);
        check("ld13_en", en, 0);
        pulse(M_RUN);
        check("run_state", state, 1);
        wait_en(cnt);
        check("run_period1", cnt, DIV);
        check("run_qpre13", q, 13);
        wait_en(cnt);
        check("run_period2", cnt, DIV);
        check("run_qpre14", q, 14);
        ens = 0;
        repeat (4) begin
            @(negedge clk);
            ens += int'(en);
        end
        check("halt_no_en", ens, 0);
        check("halt_state", state, 2);
        check("halt_q", q, 15);
        ens = 0;
        repeat (10) begin
            @(negedge clk);
            ens += int'(en);
        end
        check("halt_stays", ens, 0);
        pulse(M_RUN);
        check("halt_to_stop", state, 0);

        // Ping-pong reversal at both limits
        pingpong = 1'b1;
        d_val    = 4'd14;
        pulse(M_LOAD);
        check("ld14_load", load, 1);
        pulse(M_RUN);
        check("pp_run", state, 1);
        wait_en(cnt);
        check("pp_qpre14", q, 14);
        check("pp_up14", up, 1);
        wait_en(cnt);
        check("pp_period", cnt, DIV);
        check("pp_qpre15", q, 15);
        check("pp_rev_down", up, 0);
        for (int k = 14; k >= 1; k--) begin
            wait_en(cnt);
            check("pp_down_period", cnt, DIV);
            check("pp_down_qpre", q, k);
            check("pp_down_up", up, 0);
        end
        wait_en(cnt);
        check("pp_qpre0", q, 0);
        check("pp_rev_up", up, 1);
        pulse(M_RUN);
        check("pp_stop", state, 0);
        check("pp_q1", q, 1);
        pingpong = 1'b0;

        // Simultaneous clr + dir + step in STOP
        pulse(M_DIR);
        check("dir_toggle", up, 0);
        pulse(M_CLR | M_DIR | M_STEP);
        check("multi_n1_clr", syn_clr, 1);
        check("multi_n1_en_ld", {en, load}, 0);
        @(negedge clk);
        check("multi_n2_strobes", {en, syn_clr, load}, 0);
        check("multi_n2_up", up, 0);
        check("multi_n2_q", q, 0);
        @(negedge clk);
        check("multi_n3_up", up, 1);
        check("multi_n3_en", en, 0);
        @(negedge clk);
        check("multi_n4_en", en, 1);
        @(negedge clk);
        check("multi_q", q, 1);

        // Load coinciding with the tick terminal in RUN
        d_val = 4'd7;
        pulse(M_RUN);
        check("lt_run", state, 1);
        repeat (2) @(negedge clk);
        pulse(M_LOAD);
        check("lt_load", load, 1);
        check("lt_en", en, 0);
        wait_en(cnt);
        check("lt_restart", cnt, DIV);
        check("lt_qpre7", q, 7);

        // Reset in RUN with requests still pending
        pulse(M_CLR | M_LOAD | M_DIR);
        check("rr_clr", syn_clr, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rr_state", state, 0);
        check("rr_up", up, 1);
        check("rr_strobes", {en, syn_clr, load}, 0);
        strobes = 0;
        repeat (20) begin
            @(negedge clk);
            strobes += int'(en) + int'(syn_clr) + int'(load) + int'(!up);
        end
        check("rr_no_service", strobes, 0);
        check("rr_state_after", state, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
